// File: rtl/ram_write_buffer_pkg.sv
// Shared definitions for the RAM8 posted-write buffer: word/address widths,
// the queued entry layout and the pointer-width helper.
package ram_write_buffer_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Bits needed to index n entries (at least 1).
    function automatic int clog2(input int unsigned n);
        int          r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v != 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_wb_fwd.sv
// Youngest-match search over the write-buffer entries for read forwarding.
module ram_wb_fwd
    import ram_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = clog2(DEPTH)
) (
    input  wb_entry_t              entries [DEPTH],
    input  logic [DEPTH-1:0]       valid,
    input  logic [PTR_W-1:0]       tail,
    input  logic [WB_ADDR_W-1:0]   rd_addr,
    output logic                   hit,
    output logic [WB_DATA_W-1:0]   data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest slot position (tail) to youngest (tail-1); the last
    // valid match wins, so the youngest matching entry is reported.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail + PTR_W'(k);
            if (valid[idx] && entries[idx].addr == rd_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/ram_write_buffer.sv
// Posted-write buffer in front of RAM8: queues CPU stores, drains them in
// order through RAM8's shared port, gives CPU reads priority and forwards
// the youngest queued data on an address match.
// Optional macro WB_COALESCE_EN: a store to the youngest entry's address
// overwrites that entry instead of allocating.
module ram_write_buffer
    import ram_write_buffer_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_load,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_in,
    output logic              cpu_ready,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] cpu_rd_address,
    output logic [DATA_W-1:0] cpu_out,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic              empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [DEPTH-1:0]   valid;
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;
    logic               full;
    logic               rd_ram;
    logic               drain;
    logic               coal;
    logic               alloc;

    // Slot p is live when its distance from head is below count.
    always_comb begin
        valid = '0;
        for (int unsigned p = 0; p < DEPTH; p++) begin
            valid[p] = CNT_W'(PTR_W'(PTR_W'(p) - head)) < count;
        end
    end

    ram_wb_fwd #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entries (entries),
        .valid   (valid),
        .tail    (tail),
        .rd_addr (cpu_rd_address),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign rd_ram = cpu_rd && !fwd_hit;
    assign drain  = !reset && !empty && !rd_ram;

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] young;
    logic             coal_ok;

    // Merging into the head while it drains would lose the new data, so
    // that case falls back to a normal allocation.
    assign young     = tail - PTR_W'(1);
    assign coal_ok   = !empty && (entries[young].addr == cpu_address)
                       && !(drain && young == head);
    assign coal      = cpu_load && coal_ok;
    assign cpu_ready = !full || coal_ok;
`else
    assign coal      = 1'b0;
    assign cpu_ready = !full;
`endif

    assign alloc = cpu_load && cpu_ready && !coal;

    // Read data: forwarded entry, RAM output, or zero when not reading.
    assign cpu_out = cpu_rd ? (fwd_hit ? fwd_data : ram_out) : '0;

    // RAM8 port mux: a missing read owns the port, otherwise drain the head.
    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        if (!reset) begin
            if (rd_ram) begin
                ram_address = cpu_rd_address;
            end else if (drain) begin
                ram_load    = 1'b1;
                ram_address = entries[head].addr;
                ram_in      = entries[head].data;
            end
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) tail <= tail + PTR_W'(1);
            if (drain) head <= head + PTR_W'(1);
            count <= count + CNT_W'(alloc) - CNT_W'(drain);
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (alloc) begin
                entries[tail].addr <= cpu_address;
                entries[tail].data <= cpu_in;
            end
`ifdef WB_COALESCE_EN
            else if (coal) begin
                entries[young].data <= cpu_in;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ram_write_buffer.sv
// Directed bench for ram_write_buffer with a behavioural RAM8 attached.
module tb_ram_write_buffer;

    logic        clk;
    logic        reset;
    logic        cpu_load;
    logic [2:0]  cpu_address;
    logic [15:0] cpu_in;
    logic        cpu_ready;
    logic        cpu_rd;
    logic [2:0]  cpu_rd_address;
    logic [15:0] cpu_out;
    logic        ram_load;
    logic [2:0]  ram_address;
    logic [15:0] ram_in;
    logic [15:0] ram_out;
    logic        empty;

    logic [15:0] ram [8];

    int checks;
    int failures;

    ram_write_buffer #(
        .DATA_W (16),
        .ADDR_W (3),
        .DEPTH  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_load       (cpu_load),
        .cpu_address    (cpu_address),
        .cpu_in         (cpu_in),
        .cpu_ready      (cpu_ready),
        .cpu_rd         (cpu_rd),
        .cpu_rd_address (cpu_rd_address),
        .cpu_out        (cpu_out),
        .ram_load       (ram_load),
        .ram_address    (ram_address),
        .ram_in         (ram_in),
        .ram_out        (ram_out),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM8 model: combinational read, write on rising edge.
    assign ram_out = ram[ram_address];
    always @(posedge clk) if (ram_load) ram[ram_address] <= ram_in;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_load = 1'b0; cpu_rd = 1'b0;
        cpu_address = '0; cpu_in = '0; cpu_rd_address = '0;
        tick(); tick();
        reset = 1'b0;
        settle();
        checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL reset_ram_load got=%0h exp=0", ram_load); end
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL reset_cpu_ready got=%0h exp=1", cpu_ready); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0h exp=1", empty); end
        checks++; if (cpu_out !== 16'h0000) begin failures++; $display("FAIL reset_cpu_out got=%0h exp=0", cpu_out); end
        checks++; if (ram_address !== 3'd0) begin failures++; $display("FAIL reset_ram_address got=%0h exp=0", ram_address); end
        tick();
    endtask

    task automatic test_single_store();
        cpu_load = 1'b1; cpu_address = 3'd2; cpu_in = 16'h0011;
        settle();
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0h exp=1", cpu_ready); end
        tick();
        cpu_load = 1'b0;
        settle();
        checks++; if (ram_load !== 1'b1) begin failures++; $display("FAIL single_ram_load got=%0h exp=1", ram_load); end
        checks++; if (ram_address !== 3'd2) begin failures++; $display("FAIL single_ram_address got=%0h exp=2", ram_address); end
        checks++; if (ram_in !== 16'h0011) begin failures++; $display("FAIL single_ram_in got=%0h exp=11", ram_in); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_not_empty got=%0h exp=0", empty); end
        tick();
        cpu_rd = 1'b1; cpu_rd_address = 3'd2;
        settle();
        checks++; if (cpu_out !== 16'h0011) begin failures++; $display("FAIL single_readback got=%0h exp=11", cpu_out); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%0h exp=1", empty); end
        checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL single_idle_load got=%0h exp=0", ram_load); end
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic test_fill();
        cpu_rd = 1'b1; cpu_rd_address = 3'd7;
        for (int i = 0; i < 4; i++) begin
            cpu_load = 1'b1; cpu_address = 3'(i); cpu_in = 16'(16'hA0 + i);
            settle();
            checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%0h exp=1", i, cpu_ready); end
            checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL fill_stall[%0d] got=%0h exp=0", i, ram_load); end
            tick();
        end
        cpu_address = 3'd6; cpu_in = 16'h0BAD;
        settle();
        checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=%0h exp=0", cpu_ready); end
        checks++; if (cpu_out !== 16'h7007) begin failures++; $display("FAIL fill_rd7 got=%0h exp=7007", cpu_out); end
        tick();
        cpu_load = 1'b0; cpu_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (ram_load !== 1'b1) begin failures++; $display("FAIL drain_load[%0d] got=%0h exp=1", i, ram_load); end
            checks++; if (ram_address !== 3'(i)) begin failures++; $display("FAIL drain_addr[%0d] got=%0h exp=%0h", i, ram_address, i); end
            checks++; if (ram_in !== 16'(16'hA0 + i)) begin failures++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, ram_in, 16'hA0 + i); end
            tick();
        end
        settle();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%0h exp=1", empty); end
        checks++; if (ram[6] !== 16'h6006) begin failures++; $display("FAIL fill_dropped_store got=%0h exp=6006", ram[6]); end
        tick();
    endtask

    task automatic test_youngest();
        cpu_rd = 1'b1; cpu_rd_address = 3'd7;
        cpu_load = 1'b1; cpu_address = 3'd1; cpu_in = 16'h0101; tick();
        cpu_address = 3'd2; cpu_in = 16'h0202; tick();
        cpu_address = 3'd1; cpu_in = 16'h0303; tick();
        cpu_load = 1'b0; cpu_rd_address = 3'd1;
        settle();
        checks++; if (cpu_out !== 16'h0303) begin failures++; $display("FAIL young_fwd got=%0h exp=303", cpu_out); end
        checks++; if (ram_in !== 16'h0101 || ram_load !== 1'b1) begin failures++; $display("FAIL young_drain got=%0h/%0h exp=101/1", ram_in, ram_load); end
        tick();
        cpu_rd_address = 3'd2;
        settle();
        checks++; if (cpu_out !== 16'h0202) begin failures++; $display("FAIL young_fwd2 got=%0h exp=202", cpu_out); end
        checks++; if (ram_address !== 3'd2) begin failures++; $display("FAIL young_drain2 got=%0h exp=2", ram_address); end
        tick();
        settle();
        checks++; if (cpu_out !== 16'h0202) begin failures++; $display("FAIL young_ramread got=%0h exp=202", cpu_out); end
        checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL young_stall got=%0h exp=0", ram_load); end
        tick();
        cpu_rd = 1'b0;
        settle();
        checks++; if (ram_in !== 16'h0303 || ram_address !== 3'd1) begin failures++; $display("FAIL young_last got=%0h@%0h exp=303@1", ram_in, ram_address); end
        tick();
        settle();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL young_empty got=%0h exp=1", empty); end
        tick();
    endtask

    task automatic test_reset_mid();
        cpu_rd = 1'b1; cpu_rd_address = 3'd7;
        for (int i = 0; i < 3; i++) begin
            cpu_load = 1'b1; cpu_address = 3'(i); cpu_in = 16'(16'hC0 + i);
            tick();
        end
        cpu_load = 1'b0; cpu_rd = 1'b0; reset = 1'b1;
        settle();
        checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL rstmid_load got=%0h exp=0", ram_load); end
        tick();
        reset = 1'b0;
        settle();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%0h exp=1", empty); end
        checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL rstmid_noload got=%0h exp=0", ram_load); end
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0h exp=1", cpu_ready); end
        tick(); tick();
        settle();
        checks++; if (ram[0] !== 16'h00A0) begin failures++; $display("FAIL rstmid_ram0 got=%0h exp=a0", ram[0]); end
        checks++; if (ram[1] !== 16'h0303) begin failures++; $display("FAIL rstmid_ram1 got=%0h exp=303", ram[1]); end
        checks++; if (ram[2] !== 16'h0202) begin failures++; $display("FAIL rstmid_ram2 got=%0h exp=202", ram[2]); end
        tick();
    endtask

    task automatic test_forward();
        cpu_rd = 1'b1; cpu_rd_address = 3'd5;
        cpu_load = 1'b1; cpu_address = 3'd5; cpu_in = 16'h1111;
        settle();
        checks++; if (cpu_out !== 16'h5005) begin failures++; $display("FAIL fwd_push_invisible got=%0h exp=5005", cpu_out); end
        tick();
        cpu_in = 16'h2222;
        settle();
        checks++; if (cpu_out !== 16'h1111) begin failures++; $display("FAIL fwd_first got=%0h exp=1111", cpu_out); end
        checks++; if (ram_load !== 1'b1 || ram_in !== 16'h1111) begin failures++; $display("FAIL fwd_drain1 got=%0h/%0h exp=1/1111", ram_load, ram_in); end
        tick();
        cpu_load = 1'b0;
        settle();
        checks++; if (cpu_out !== 16'h2222) begin failures++; $display("FAIL fwd_second got=%0h exp=2222", cpu_out); end
        checks++; if (ram_load !== 1'b1 || ram_in !== 16'h2222) begin failures++; $display("FAIL fwd_drain2 got=%0h/%0h exp=1/2222", ram_load, ram_in); end
        tick();
        settle();
        checks++; if (cpu_out !== 16'h2222) begin failures++; $display("FAIL fwd_ramread got=%0h exp=2222", cpu_out); end
        checks++; if (ram[5] !== 16'h2222) begin failures++; $display("FAIL fwd_ram5 got=%0h exp=2222", ram[5]); end
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic test_coalesce();
        cpu_rd = 1'b1; cpu_rd_address = 3'd6;
        cpu_load = 1'b1; cpu_address = 3'd4; cpu_in = 16'h0001; tick();
        cpu_in = 16'h0002;
        settle();
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL coal_ready got=%0h exp=1", cpu_ready); end
        checks++; if (cpu_out !== 16'h6006) begin failures++; $display("FAIL coal_rd6 got=%0h exp=6006", cpu_out); end
        tick();
        cpu_load = 1'b0; cpu_rd_address = 3'd4;
        settle();
        checks++; if (cpu_out !== 16'h0002) begin failures++; $display("FAIL coal_fwd got=%0h exp=2", cpu_out); end
`ifdef WB_COALESCE_EN
        checks++; if (ram_in !== 16'h0002) begin failures++; $display("FAIL coal_drain got=%0h exp=2", ram_in); end
        tick();
        cpu_rd = 1'b0;
        settle();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL coal_count got=%0h exp=1", empty); end
        checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL coal_noload got=%0h exp=0", ram_load); end
`else
        checks++; if (ram_in !== 16'h0001) begin failures++; $display("FAIL coal_drain got=%0h exp=1", ram_in); end
        tick();
        cpu_rd = 1'b0;
        settle();
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL coal_count got=%0h exp=0", empty); end
        checks++; if (ram_in !== 16'h0002) begin failures++; $display("FAIL coal_drain2 got=%0h exp=2", ram_in); end
        tick();
        settle();
`endif
        checks++; if (ram[4] !== 16'h0002) begin failures++; $display("FAIL coal_ram4 got=%0h exp=2", ram[4]); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 8; i++) ram[i] = 16'(i * 16'h1001);
        test_reset();
        test_single_store();
        test_fill();
        test_youngest();
        test_reset_mid();
        test_forward();
        test_coalesce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_write_buffer.md
Name: ram_write_buffer

Overview:
Posted-write buffer sitting directly upstream of the RAM8 data memory. It accepts CPU stores in one cycle, queues them in a small FIFO, and drains them into RAM8 through RAM8's single shared address port. CPU reads take that port with priority. A read returns the youngest queued data for a matching address; otherwise it returns RAM8's output.

Parameters:
DATA_W, 16, data word width (matches RAM8 in/out)
ADDR_W, 3, RAM address width (RAM8 = 8 words)
DEPTH, 4, queue entries; power of 2, >= 2

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high; flushes the queue
cpu_load  in  1  store request
cpu_address  in  ADDR_W  store address
cpu_in  in  DATA_W  store data
cpu_ready  out  1  store accepted this cycle (= not full)
cpu_rd  in  1  read request this cycle
cpu_rd_address  in  ADDR_W  read address
cpu_out  out  DATA_W  read data (combinational)
ram_load  out  1  to RAM8 load
ram_address  out  ADDR_W  to RAM8 address
ram_in  out  DATA_W  to RAM8 in
ram_out  in  DATA_W  from RAM8 out (combinational read of ram_address)
empty  out  1  queue holds no entries

Behaviour:
- State: DEPTH entries {addr, data}, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- Reset: count=0 and pointers=0, giving ram_load=0, cpu_ready=1, empty=1. Entry contents are don't-care. Reset mid-drain discards all pending writes, and no ram_load is asserted in the reset cycle.
- Push: at the clk edge when cpu_load && cpu_ready, {cpu_address, cpu_in} is written at tail and tail increments. With cpu_load while full, the store is ignored; the CPU must hold it until cpu_ready=1. Full blocks a push even if a drain happens the same cycle.
- Forward hit (fwd_hit): cpu_rd=1 and some queued entry has addr==cpu_rd_address. cpu_out = data of the youngest matching entry (nearest tail). An entry being pushed this cycle is not visible to that read.
- Read: if cpu_rd && !fwd_hit, then ram_address=cpu_rd_address, ram_load=0, cpu_out=ram_out, and the drain stalls this cycle. If cpu_rd=0, cpu_out=0.
- Drain: when count>0 and !(cpu_rd && !fwd_hit), drive ram_load=1, ram_address=head.addr, ram_in=head.data. RAM8 captures at the edge; head increments and count decrements.
- Idle: when neither reading the RAM nor draining, ram_address=0 and ram_in=0.
- Simultaneous push and drain: count unchanged, both pointers advance.
- Latency: a store accepted at edge N reaches RAM8 at edge N+1 at the earliest. A continuous non-hitting read stream can starve the drain indefinitely; this is by design.
- Ordering: writes drain in strict acceptance order, so same-address writes land last-wins.
- cpu_ready = (count != DEPTH); empty = (count == 0).

Optional Feature:
WB_COALESCE_EN
- Defined: a push whose address equals the youngest entry's addr overwrites that entry's data, with no allocation and no tail or count change. This applies even when full (cpu_ready is then 1 for that address only). It is suppressed if that entry is the head being drained the same cycle; the push then allocates normally.
- Undefined: every accepted push allocates a new entry.

Decomposition:
- Shared package/include holds: DATA_W and ADDR_W constants, the entry struct {addr, data}, and the pointer-width function clog2(DEPTH).
- One sub-module: ram_wb_fwd. It is a combinational youngest-match priority search over the entries. Inputs are the entry array, valid mask, tail and rd address; outputs are hit and data.

Test Plan:
- Reset then idle: ram_load=0, cpu_ready=1, empty=1, and cpu_out=0 with cpu_rd=0.
- Store 0x0011 to address 2, no reads: ram_load=1, ram_address=2, ram_in=0x0011 in the following cycle. A later read of address 2 returns 0x0011 from RAM and empty=1.
- Four stores to addresses 0..3 (0xA0..0xA3) with cpu_rd held at address 7: the queue fills, cpu_ready=0, and a fifth store is ignored. Dropping cpu_rd drains addresses 0,1,2,3 in order over 4 cycles.
- Store 0x1111 then 0x2222 to address 5 while reading address 5: cpu_out=0x2222 via forwarding, the drain continues, and the final RAM[5]=0x2222.
- Assert reset with 3 entries queued: no further ram_load, empty=1, and the RAM contents for those addresses are unchanged.
- WB_COALESCE_EN defined, drain blocked by a read of a non-queued address: stores to address 4 with 0x1 then 0x2 give count=1 and data 0x2. Undefined: count=2.
